mod_exp_ctrl: RTL and testbench

- Sequencer that computes result = msg^exp mod M (left-to-right binary square-and-multiply).
- Issues every step to one external Montgomery-product unit (start / A / B / M / count → stop / P).
- Handles conversion into the Montgomery domain, the exponent bit loop, and conversion back out.
- Sits between the RSA top-level command logic and the single shared Montgomery multiplier.

---
 rtl/mod_exp_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier.
// Optional MOD_EXP_SKIP_LZ_EN: skip leading zero exponent bits without multiplier ops.
module mod_exp_ctrl #(
   parameter int WIDTH  = 1024,
   parameter int CNT_W  = 10,
   parameter int ELEN_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WIDTH-1:0]  msg,
   input  logic [WIDTH-1:0]  exp,
   input  logic [ELEN_W-1:0] e_len,
   input  logic [WIDTH-1:0]  modulus,
   input  logic [WIDTH-1:0]  r2_mod,
   input  logic [CNT_W-1:0]  mp_cnt_cfg,
   output logic              ready,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic              mp_start,
   output logic [WIDTH-1:0]  mp_a,
   output logic [WIDTH-1:0]  mp_b,
   output logic [WIDTH-1:0]  mp_m,
   output logic [CNT_W-1:0]  mp_count,
   input  logic              mp_done,
   input  logic [WIDTH:0]    mp_p
);
   // state | meaning
   // IDLE  | waiting for start while the multiplier is idle
   // TOX   | xm  = msg * R mod M
   // TOA   | acc = R mod M (Montgomery one)
   // SCAN  | skip leading zero exponent bits (MOD_EXP_SKIP_LZ_EN only)
   // SQR   | acc = acc * acc
   // MUL   | acc = acc * xm
   // NEXT  | advance to the next lower exponent bit
   // FROM  | result = acc out of the Montgomery domain
   // WAIT  | multiplier running; capture product into dst, return to ret_state
   // FIN   | done pulse
`ifdef MOD_EXP_SKIP_LZ_EN
   typedef enum logic [3:0] {S_IDLE, S_TOX, S_TOA, S_SCAN, S_SQR, S_MUL, S_NEXT,
                             S_FROM, S_WAIT, S_FIN} state_t;
`else
   typedef enum logic [3:0] {S_IDLE, S_TOX, S_TOA, S_SQR, S_MUL, S_NEXT,
                             S_FROM, S_WAIT, S_FIN} state_t;
`endif
   typedef enum logic [1:0] {D_XM, D_ACC, D_RES} dst_t;

   localparam logic [ELEN_W-1:0] WIDTH_L = ELEN_W'(WIDTH);

   state_t             state, state_n, ret_state, op_ret;
   dst_t               dst, op_dst;
   logic [1:0]         wait_cnt;
   logic [WIDTH-1:0]   msg_q, exp_q, r2_q, xm, acc;
   logic [WIDTH-1:0]   op_a, op_b;
   logic [ELEN_W-1:0]  bit_idx, eff_len;
   logic               zero_len, mp_done_q;
   logic               issue, capture, accept, bit_dec, acc_from_xm, cur_bit;
   logic               unused_p_msb;

   assign unused_p_msb = mp_p[WIDTH];
   assign ready        = (state == S_IDLE) && mp_done_q;
   assign done         = (state == S_FIN);
   assign eff_len      = (e_len > WIDTH_L) ? WIDTH_L : e_len;
   assign cur_bit      = |(exp_q & (WIDTH'(1) << bit_idx));

   always_comb begin
      state_n     = state;
      issue       = 1'b0;
      capture     = 1'b0;
      accept      = 1'b0;
      bit_dec     = 1'b0;
      acc_from_xm = 1'b0;
      op_a        = '0;
      op_b        = '0;
      op_dst      = D_ACC;
      op_ret      = S_IDLE;
      case (state)
         S_IDLE: if (start && ready) begin
            accept  = 1'b1;
            state_n = S_TOX;
         end
         S_TOX: begin
            issue = 1'b1; op_a = msg_q; op_b = r2_q; op_dst = D_XM; op_ret = S_TOA;
         end
         S_TOA: begin
            issue = 1'b1; op_a = WIDTH'(1); op_b = r2_q;
`ifdef MOD_EXP_SKIP_LZ_EN
            op_ret = zero_len ? S_FROM : S_SCAN;
`else
            op_ret = zero_len ? S_FROM : S_SQR;
`endif
         end
`ifdef MOD_EXP_SKIP_LZ_EN
         S_SCAN: begin
            // the first set bit would square R and multiply by xm, i.e. acc = xm
            if (cur_bit) begin
               acc_from_xm = 1'b1;
               state_n     = S_NEXT;
            end else if (bit_idx == '0) begin
               state_n = S_FROM;
            end else begin
               bit_dec = 1'b1;
            end
         end
`endif
         S_SQR: begin
            issue = 1'b1; op_a = acc; op_b = acc; op_ret = cur_bit ? S_MUL : S_NEXT;
         end
         S_MUL: begin
            issue = 1'b1; op_a = acc; op_b = xm; op_ret = S_NEXT;
         end
         S_NEXT: begin
            if (bit_idx == '0) begin
               state_n = S_FROM;
            end else begin
               bit_dec = 1'b1;
               state_n = S_SQR;
            end
         end
         S_FROM: begin
            issue = 1'b1; op_a = acc; op_b = WIDTH'(1); op_dst = D_RES; op_ret = S_FIN;
         end
         S_WAIT: if (wait_cnt == 2'd3 && mp_done) begin
            capture = 1'b1;
            state_n = ret_state;
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (issue) state_n = S_WAIT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ret_state <= S_IDLE;
         dst       <= D_ACC;
         wait_cnt  <= '0;
         mp_done_q <= 1'b0;
         mp_start  <= 1'b0;
         mp_a      <= '0;
         mp_b      <= '0;
         mp_m      <= '0;
         mp_count  <= '0;
         result    <= '0;
         msg_q     <= '0;
         exp_q     <= '0;
         r2_q      <= '0;
         xm        <= '0;
         acc       <= '0;
         bit_idx   <= '0;
         zero_len  <= 1'b0;
      end else begin
         state     <= state_n;
         mp_done_q <= mp_done;
         mp_start  <= issue;
         if (accept) begin
            msg_q    <= msg;
            exp_q    <= exp;
            r2_q     <= r2_mod;
            mp_m     <= modulus;
            mp_count <= mp_cnt_cfg;
            bit_idx  <= eff_len - ELEN_W'(1);
            zero_len <= (eff_len == '0);
         end
         if (issue) begin
            mp_a      <= op_a;
            mp_b      <= op_b;
            dst       <= op_dst;
            ret_state <= op_ret;
            wait_cnt  <= '0;
         end else if (state == S_WAIT && wait_cnt != 2'd3) begin
            // the multiplier loads its count late, so mp_done is stale for a few cycles
            wait_cnt <= wait_cnt + 2'd1;
         end
         if (capture) begin
            case (dst)
               D_XM:    xm     <= mp_p[WIDTH-1:0];
               D_ACC:   acc    <= mp_p[WIDTH-1:0];
               D_RES:   result <= mp_p[WIDTH-1:0];
               default: ;
            endcase
         end
         if (acc_from_xm) acc <= xm;
         if (bit_dec) bit_idx <= bit_idx - ELEN_W'(1);
      end
   end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural Montgomery multiplier (R = 2^16).
module tb_mod_exp_ctrl;
   localparam int W = 16;
   localparam int CW = 10;
   localparam int EW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  msg, exp, modulus, r2_mod;
   logic [EW-1:0] e_len;
   logic [CW-1:0] mp_cnt_cfg;
   logic          ready, done, mp_start;
   logic [W-1:0]  result, mp_a, mp_b, mp_m;
   logic [CW-1:0] mp_count;
   logic          mp_done;
   logic [W:0]    mp_p;

   int n_tests = 0;
   int n_fail  = 0;
   int n_starts = 0;
   int n_dones  = 0;
   int lat;
   int base_s, base_d;
   logic ok;

   always #5 clk = ~clk;

   mod_exp_ctrl #(.WIDTH(W), .CNT_W(CW), .ELEN_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .exp(exp), .e_len(e_len),
      .modulus(modulus), .r2_mod(r2_mod), .mp_cnt_cfg(mp_cnt_cfg), .ready(ready),
      .done(done), .result(result), .mp_start(mp_start), .mp_a(mp_a), .mp_b(mp_b),
      .mp_m(mp_m), .mp_count(mp_count), .mp_done(mp_done), .mp_p(mp_p));

   function automatic logic [W:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] m);
      logic [63:0] t;
      t = 64'(a) * 64'(b);
      for (int i = 0; i < W; i++) begin
         if (t[0]) t = t + 64'(m);
         t = t >> 1;
      end
      if (t >= 64'(m)) t = t - 64'(m);
      return t[W:0];
   endfunction

   // behavioural multiplier: no reset, drops mp_done one cycle after start
   logic         mdl_arm = 1'b0;
   int           mdl_cnt = 0;
   logic [W:0]   mdl_val = '0;
   initial begin mp_done = 1'b1; mp_p = '0; end
   always @(posedge clk) begin
      if (mp_start) begin
         mdl_arm <= 1'b1;
         mdl_val <= mont(mp_a, mp_b, mp_m);
      end else if (mdl_arm) begin
         mdl_arm <= 1'b0;
         mp_done <= 1'b0;
         mdl_cnt <= lat;
      end else if (!mp_done) begin
         if (mdl_cnt == 0) begin
            mp_done <= 1'b1;
            mp_p    <= mdl_val;
         end else begin
            mdl_cnt <= mdl_cnt - 1;
         end
      end
      if (mp_start) n_starts++;
      if (done) n_dones++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic wait_ready(output logic got);
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         got = ready;
      end
   endtask

   task automatic wait_done(output logic got);
      got = 1'b0;
      for (int i = 0; i < 4000 && !got; i++) begin
         @(negedge clk);
         got = done;
      end
   endtask

   task automatic issue(input logic [W-1:0] m, input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [EW-1:0] el);
      logic got;
      wait_ready(got);
      check("ready_before_start", 32'(got), 32'd1);
      base_s = n_starts;
      base_d = n_dones;
      modulus = m; msg = b; exp = e; e_len = el;
      r2_mod  = W'((64'd1 << (2 * W)) % 64'(m));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run(input string tag, input logic [W-1:0] m, input logic [W-1:0] b,
                      input logic [W-1:0] e, input logic [EW-1:0] el,
                      input int exp_res, input int exp_starts);
      logic got;
      issue(m, b, e, el);
      wait_done(got);
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      check({tag, "_result"}, 32'(result), 32'(exp_res));
      repeat (3) @(negedge clk);
      check({tag, "_starts"}, 32'(n_starts - base_s), 32'(exp_starts));
      check({tag, "_dones"}, 32'(n_dones - base_d), 32'd1);
      check({tag, "_held"}, 32'(result), 32'(exp_res));
   endtask

   initial begin
      logic got;
      lat = 3;
      rst_n = 1'b0; start = 1'b0; msg = '0; exp = '0; e_len = '0;
      modulus = '0; r2_mod = '0; mp_cnt_cfg = 10'd16;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mp_start", 32'(mp_start), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_mp_a", 32'(mp_a), 32'd0);
      check("rst_mp_m", 32'(mp_m), 32'd0);
      check("rst_mp_count", 32'(mp_count), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("ready_after_rst", 32'(ready), 32'd1);

      run("c1", 16'd13, 16'd5, 16'd3, 5'd2, 8, 7);
      check("c1_mp_m", 32'(mp_m), 32'd13);
      check("c1_mp_count", 32'(mp_count), 32'd16);
`ifdef MOD_EXP_SKIP_LZ_EN
      run("c2", 16'd13, 16'd5, 16'd3, 5'd4, 8, 5);
`else
      run("c2", 16'd13, 16'd5, 16'd3, 5'd4, 8, 9);
`endif
      run("c3", 16'd13, 16'd7, 16'd0, 5'd0, 1, 3);
`ifdef MOD_EXP_SKIP_LZ_EN
      run("clamp", 16'd13, 16'd5, 16'd3, 5'd20, 8, 5);
`else
      run("clamp", 16'd13, 16'd5, 16'd3, 5'd20, 8, 21);
`endif

      // case 4: start held high with other operands while busy
      issue(16'd13, 16'd5, 16'd3, 5'd2);
      modulus = 16'd11; msg = 16'd2; exp = 16'd10; e_len = 5'd4; start = 1'b1;
      repeat (10) @(negedge clk);
      start = 1'b0;
      wait_done(got);
      check("c4_done_seen", 32'(got), 32'd1);
      check("c4_result", 32'(result), 32'd8);
      repeat (10) @(negedge clk);
      check("c4_dones", 32'(n_dones - base_d), 32'd1);
      check("c4_starts", 32'(n_starts - base_s), 32'd7);

      // case 5: reset during the first SQR while the multiplier is busy
      lat = 20;
      issue(16'd11, 16'd2, 16'd10, 5'd4);
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         got = (n_starts - base_s) >= 3;
      end
      check("c5_reached_sqr", 32'(got), 32'd1);
      repeat (3) @(negedge clk);
      check("c5_model_busy", 32'(mp_done), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      check("c5_rst_ready", 32'(ready), 32'd0);
      check("c5_rst_done", 32'(done), 32'd0);
      check("c5_rst_mp_start", 32'(mp_start), 32'd0);
      check("c5_rst_result", 32'(result), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("c5_ready_drain", 32'(ready), 32'd0);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = mp_done;
      end
      check("c5_model_drained", 32'(got), 32'd1);
      repeat (2) @(negedge clk);
      check("c5_ready_back", 32'(ready), 32'd1);
      lat = 3;
`ifdef MOD_EXP_SKIP_LZ_EN
      run("c5", 16'd11, 16'd2, 16'd10, 5'd4, 1, 7);
`else
      run("c5", 16'd11, 16'd2, 16'd10, 5'd4, 1, 9);
`endif

      // case 6: slow multiplier
      lat = 43;
      run("c6", 16'd13, 16'd5, 16'd3, 5'd2, 8, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
